// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - non-pipelined instruction fetch engine between the IF PC register and ID
`timescale 1ns/1ps

module instruction_fetch #(
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0000,
  parameter logic        ALIGN_CHECK     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic [31:0] pc,
  input  logic        redirect,
  output logic        stall_request,
  output logic        bus_request,
  output logic [31:0] bus_address,
  input  logic        bus_ready,
  input  logic        bus_read_valid,
  input  logic [31:0] bus_read_data,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  output logic        fetch_exception
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT_DATA,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_bus_request, w_bus_request_next;
  logic [31:0] r_bus_address, w_bus_address_next;
  logic [31:0] r_instruction, w_instruction_next;
  logic [31:0] r_instruction_pc, w_instruction_pc_next;
  logic        r_valid, w_valid_next;
  logic        r_exception, w_exception_next;
  logic [31:0] r_hold_data, w_hold_data_next;
  logic        w_stall_request;
  logic        w_id_stall;
  logic        w_misaligned;
  logic        w_unused_stall;

  assign w_id_stall     = stall[1];
  assign w_misaligned   = ALIGN_CHECK && (pc[1:0] != 2'b00);
  assign w_unused_stall = ^{stall[5:2], stall[0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_bus_request    <= 1'b0;
      r_bus_address    <= 32'h0;
      r_instruction    <= NOP_INSTRUCTION;
      r_instruction_pc <= 32'h0;
      r_valid          <= 1'b0;
      r_exception      <= 1'b0;
      r_hold_data      <= 32'h0;
    end else begin
      r_state          <= w_state_next;
      r_bus_request    <= w_bus_request_next;
      r_bus_address    <= w_bus_address_next;
      r_instruction    <= w_instruction_next;
      r_instruction_pc <= w_instruction_pc_next;
      r_valid          <= w_valid_next;
      r_exception      <= w_exception_next;
      r_hold_data      <= w_hold_data_next;
    end
  end

  always_comb begin
    w_state_next          = r_state;
    w_bus_request_next    = r_bus_request;
    w_bus_address_next    = r_bus_address;
    w_instruction_next    = r_instruction;
    w_instruction_pc_next = r_instruction_pc;
    w_valid_next          = r_valid;
    w_exception_next      = r_exception;
    w_hold_data_next      = r_hold_data;
    w_stall_request       = 1'b0;

    // An unstalled ID stage consumes the slot, so a bubble follows unless a delivery overrides it.
    if (!w_id_stall) begin
      w_instruction_next = NOP_INSTRUCTION;
      w_valid_next       = 1'b0;
      w_exception_next   = 1'b0;
    end

    if (redirect) begin
      w_instruction_next = NOP_INSTRUCTION;
      w_valid_next       = 1'b0;
      w_exception_next   = 1'b0;
      w_hold_data_next   = 32'h0;
      case (r_state)
        S_REQUEST: begin
          w_bus_request_next = 1'b0;
          w_state_next       = bus_ready ? S_DISCARD : S_IDLE;
        end
        S_WAIT_DATA, S_DISCARD: w_state_next = bus_read_valid ? S_IDLE : S_DISCARD;
        default:                w_state_next = S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_id_stall) begin
            if (w_misaligned) begin
              w_instruction_next    = NOP_INSTRUCTION;
              w_instruction_pc_next = pc;
              w_valid_next          = 1'b1;
              w_exception_next      = 1'b1;
            end else begin
              w_stall_request    = 1'b1;
              w_bus_request_next = 1'b1;
              w_bus_address_next = pc;
              w_state_next       = S_REQUEST;
            end
          end
        end
        S_REQUEST: begin
          w_stall_request = 1'b1;
          if (bus_ready) begin
            w_bus_request_next = 1'b0;
            w_state_next       = S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          w_stall_request = 1'b1;
          if (bus_read_valid) begin
            if (w_id_stall) begin
              w_hold_data_next = bus_read_data;
              w_state_next     = S_HOLD;
            end else begin
              w_stall_request       = 1'b0;
              w_instruction_next    = bus_read_data;
              w_instruction_pc_next = r_bus_address;
              w_valid_next          = 1'b1;
              w_exception_next      = 1'b0;
              w_state_next          = S_IDLE;
            end
          end
        end
        S_HOLD: begin
          w_stall_request = w_id_stall;
          if (!w_id_stall) begin
            w_instruction_next    = r_hold_data;
            w_instruction_pc_next = r_bus_address;
            w_valid_next          = 1'b1;
            w_exception_next      = 1'b0;
            w_state_next          = S_IDLE;
          end
        end
        S_DISCARD: begin
          w_stall_request = 1'b1;
          if (bus_read_valid) begin
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign stall_request     = w_stall_request;
  assign bus_request       = r_bus_request;
  assign bus_address       = r_bus_address;
  assign instruction       = r_instruction;
  assign instruction_pc    = r_instruction_pc;
  assign instruction_valid = r_valid;
  assign fetch_exception   = r_exception;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed scoreboard bench for instruction_fetch
`timescale 1ns/1ps

module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic [31:0] pc;
  logic        redirect;
  logic        stall_request;
  logic        bus_request;
  logic [31:0] bus_address;
  logic        bus_ready;
  logic        bus_read_valid;
  logic [31:0] bus_read_data;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        instruction_valid;
  logic        fetch_exception;

  int total = 0;
  int bad   = 0;
  logic [64:0] sb[$];
  logic        upd = 1'b0;

  instruction_fetch #(
    .NOP_INSTRUCTION (NOP),
    .ALIGN_CHECK     (1'b1)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .stall             (stall),
    .pc                (pc),
    .redirect          (redirect),
    .stall_request     (stall_request),
    .bus_request       (bus_request),
    .bus_address       (bus_address),
    .bus_ready         (bus_ready),
    .bus_read_valid    (bus_read_valid),
    .bus_read_data     (bus_read_data),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc),
    .instruction_valid (instruction_valid),
    .fetch_exception   (fetch_exception)
  );

  always #5 clock = ~clock;

  // Outputs are only refreshed on an edge where ID was not stalled; track that to count each delivery once.
  always @(posedge clock) upd <= reset && !stall[1];

  always @(negedge clock) begin
    if (reset && upd && instruction_valid) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_delivery observed=%h/%h/%b expected=none",
               instruction, instruction_pc, fetch_exception);
      end
      if (sb.size() > 0) begin
        logic [64:0] exp;
        exp = sb.pop_front();
        total++;
        assert ({instruction, instruction_pc, fetch_exception} === exp) else begin
          bad++;
          $error("FAIL delivery observed=%h/%h/%b expected=%h/%h/%b",
                 instruction, instruction_pc, fetch_exception, exp[64:33], exp[32:1], exp[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
    pc = a;
    #1 chk("idle_sreq", 32'(stall_request), 32'd1);
    tick();
    chk("req_valid_bubble", 32'(instruction_valid), 32'd0);
    chk("req_bus_request", 32'(bus_request), 32'd1);
    chk("req_bus_address", bus_address, a);
    bus_ready = 1'b1;
    #1 chk("req_sreq", 32'(stall_request), 32'd1);
    tick();
    bus_ready = 1'b0;
    chk("wait_bus_request", 32'(bus_request), 32'd0);
    for (int i = 1; i < lat; i++) begin
      chk("wait_sreq", 32'(stall_request), 32'd1);
      tick();
    end
    bus_read_valid = 1'b1;
    bus_read_data  = d;
    sb.push_back({d, a, 1'b0});
    #1 chk("rv_sreq", 32'(stall_request), 32'd0);
    tick();
    bus_read_valid = 1'b0;
    bus_read_data  = 32'h0;
    pc = a + 32'd4;
  endtask

  initial begin
    reset = 1'b0; stall = 6'b0; pc = 32'h0; redirect = 1'b0;
    bus_ready = 1'b0; bus_read_valid = 1'b0; bus_read_data = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_bus_request", 32'(bus_request), 32'd0);
    chk("rst_bus_address", bus_address, 32'h0);
    chk("rst_instruction", instruction, NOP);
    chk("rst_instruction_pc", instruction_pc, 32'h0);
    chk("rst_valid", 32'(instruction_valid), 32'd0);
    chk("rst_exception", 32'(fetch_exception), 32'd0);
    reset = 1'b1;

    fetch(32'h0000_0000, 32'h2408_0005, 2);
    fetch(32'h0000_0004, 32'h2409_0006, 2);
    fetch(32'h0000_0008, 32'h240A_0007, 2);

    // Redirect while waiting; the stale word must be swallowed.
    pc = 32'h0000_000C;
    tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    redirect = 1'b1;
    #1 chk("redir_sreq", 32'(stall_request), 32'd0);
    tick();
    redirect = 1'b0;
    pc = 32'h0000_0100;
    chk("redir_valid", 32'(instruction_valid), 32'd0);
    chk("redir_exception", 32'(fetch_exception), 32'd0);
    for (int i = 0; i < 2; i++) begin
      #1 chk("discard_sreq", 32'(stall_request), 32'd1);
      chk("discard_bus_request", 32'(bus_request), 32'd0);
      tick();
    end
    bus_read_valid = 1'b1;
    bus_read_data  = 32'hDEAD_BEEF;
    tick();
    bus_read_valid = 1'b0;
    bus_read_data  = 32'h0;
    chk("post_discard_bus_request", 32'(bus_request), 32'd0);
    fetch(32'h0000_0100, 32'h8C0A_0010, 1);

    // ID stalled while idle: outputs hold, no new access.
    stall = 6'b000010;
    #1 chk("idle_stall_sreq", 32'(stall_request), 32'd0);
    tick();
    chk("idle_stall_valid", 32'(instruction_valid), 32'd1);
    chk("idle_stall_instr", instruction, 32'h8C0A_0010);
    chk("idle_stall_pc", instruction_pc, 32'h0000_0100);
    chk("idle_stall_bus_request", 32'(bus_request), 32'd0);
    stall = 6'b0;

    // Response arrives under ID stall and sits in the hold buffer for 4 cycles.
    pc = 32'h0000_0104;
    tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    bus_read_valid = 1'b1;
    bus_read_data  = 32'h1234_5678;
    stall = 6'b000010;
    #1 chk("hold_rv_sreq", 32'(stall_request), 32'd1);
    tick();
    bus_read_valid = 1'b0;
    bus_read_data  = 32'h0;
    for (int k = 1; k < 4; k++) begin
      chk("hold_valid", 32'(instruction_valid), 32'd0);
      chk("hold_instr", instruction, NOP);
      #1 chk("hold_sreq", 32'(stall_request), 32'd1);
      tick();
    end
    stall = 6'b0;
    sb.push_back({32'h1234_5678, 32'h0000_0104, 1'b0});
    #1 chk("hold_release_sreq", 32'(stall_request), 32'd0);
    tick();

    // Misaligned PC faults without touching the bus.
    pc = 32'h0000_0002;
    sb.push_back({NOP, 32'h0000_0002, 1'b1});
    #1 chk("misalign_sreq", 32'(stall_request), 32'd0);
    tick();
    chk("misalign_bus_request", 32'(bus_request), 32'd0);
    fetch(32'h0000_0200, 32'hAC0B_0020, 3);

    // Asynchronous reset in the middle of WAIT_DATA.
    pc = 32'h0000_0300;
    tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    chk("pre_reset_address", bus_address, 32'h0000_0300);
    #3 reset = 1'b0;
    #1;
    chk("async_bus_request", 32'(bus_request), 32'd0);
    chk("async_bus_address", bus_address, 32'h0);
    chk("async_instruction", instruction, NOP);
    chk("async_instruction_pc", instruction_pc, 32'h0);
    chk("async_valid", 32'(instruction_valid), 32'd0);
    chk("async_exception", 32'(fetch_exception), 32'd0);
    tick();
    reset = 1'b1;
    fetch(32'h0000_0300, 32'h0000_0008, 2);

    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
